fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Consumer side of the instruction-translation lookup. It drives the 6-bit virtual address into the lookup and captures the returned 16-bit word.
- Assembles complete instructions, one word or two words (MVI plus its immediate), and hands them to the processor core over a valid/ready handshake.
- Owns the program counter and accepts PC redirects from the core (MVNZ, jumps).
- Sits between the translation lookup and the core's decode stage.

Parameters:
- ADDR_W, 6: virtual address width.
- DATA_W, 16: instruction word width.
- PROG_LEN, 38: number of valid program words; PC == PROG_LEN means end of program.
- OP_MVI, 4'b0001: opcode value, in I field [9:6], that carries a trailing immediate word.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that leaves IDLE.
- addr  out  ADDR_W  lookup address; combinationally equal to pc.
- word  in  DATA_W  lookup result for addr, valid in the same cycle.
- instr_valid  out  1  instr/imm/has_imm/instr_pc hold a complete instruction.
- instr_ready  in  1  core accepts the instruction when valid && ready.
- instr  out  DATA_W  opcode word.
- imm  out  DATA_W  immediate word; 0 when has_imm=0.
- has_imm  out  1  instr is MVI; imm is meaningful.
- instr_pc  out  ADDR_W  address of the opcode word.
- pc_load  in  1  redirect request.
- pc_target  in  ADDR_W  redirect address.
- halted  out  1  program end reached.

Behaviour:
- Reset, asynchronous on Resetn=0:
  - state=IDLE, pc=0, so addr=0.
  - instr, imm and instr_pc=0.
  - instr_valid, has_imm and halted=0.
  - Any in-flight fetch is discarded.
- IDLE: wait for start=1, then go to FETCH. pc_load in IDLE sets pc only and stays in IDLE.
- FETCH:
  - addr=pc. At the edge: instr<=word, instr_pc<=pc, pc<=pc+1 (wraps mod 2^ADDR_W).
  - If word[9:6]==OP_MVI: has_imm<=1 and go to FETCH_IMM.
  - Otherwise: has_imm<=0, imm<=0, go to HOLD.
- FETCH_IMM: addr=pc. At the edge: imm<=word, pc<=pc+1, go to HOLD. The immediate is fetched even when pc>=PROG_LEN; the lookup returns whatever it holds, normally 0.
- HOLD:
  - instr_valid=1. Outputs stay stable until accepted.
  - On instr_ready=1: if pc>=PROG_LEN go to HALT (halted<=1), else go to FETCH.
  - Minimum throughput is one instruction per 2 cycles, or 3 cycles for MVI.
- HALT:
  - halted=1, instr_valid=0, no fetches.
  - Left only by reset or by pc_load with pc_target<PROG_LEN, which goes to FETCH with halted<=0.
- Redirect, pc_load=1 in FETCH, FETCH_IMM, HOLD or HALT:
  - Highest priority.
  - Any partially fetched or unaccepted instruction is dropped; instr_valid is 0 the next cycle.
  - pc<=pc_target.
  - Go to FETCH, or to HALT if pc_target>=PROG_LEN.
- pc_load together with instr_ready in HOLD: the current instruction counts as accepted, then the redirect applies.
- start outside IDLE is ignored.
- Latency: start to first instr_valid is 2 cycles for a non-MVI word and 3 for MVI. Redirect to valid follows the same rule.

Decomposition:
- Shared package (isa_pkg):
  - Opcode constants: MV=0000, MVI=0001, MVNZ=0011, LD=0100, SD=0101, ADD=0110, SUB=0111, OR=1000, SLT=1001, SLL=1010, SRL=1011.
  - Field positions: Y[15:13], X[12:10], I[9:6].
  - Fetch state enum: IDLE, FETCH, FETCH_IMM, HOLD, HALT.
- One natural sub-module: fetch_pc_reg, a loadable, incrementing, wrapping PC register with async active-low clear.

Test Plan:
- Reset then start, program loaded, instr_ready=1:
  - Cycle 3: instr=0x0040, has_imm=1, imm=0x0002, instr_pc=0.
  - Next: instr=0x0440, imm=0x0003, instr_pc=2.
  - Then: instr=0x0580, has_imm=0, imm=0, instr_pc=4.
- Backpressure: hold instr_ready=0 for 5 cycles at instr_pc=4. instr stays 0x0580 and instr_valid stays 1 throughout, with no pc change. Raise ready and the next instr is 0x0840 from pc 5.
- Redirect: pc_load=1 with pc_target=5 during FETCH_IMM of pc 0. The partial instruction is dropped, and the next valid output is instr=0x0840, imm=0x0006, instr_pc=5.
- End of program:
  - pc_load to target 37 gives instr=0x2180. After acceptance halted=1 and instr_valid stays 0.
  - pc_load to target 40 from HOLD gives HALT directly.
  - pc_load to target 0 from HALT resumes with instr=0x0040.
- Reset mid-operation: assert Resetn=0 asynchronously in FETCH_IMM. All outputs go to 0 immediately and addr=0. start after release refetches from pc 0.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch path: opcodes, instruction field positions
// and the fetch sequencer state encoding.
package isa_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;

    localparam logic [3:0] OPC_MV   = 4'b0000;
    localparam logic [3:0] OPC_MVI  = 4'b0001;
    localparam logic [3:0] OPC_MVNZ = 4'b0011;
    localparam logic [3:0] OPC_LD   = 4'b0100;
    localparam logic [3:0] OPC_SD   = 4'b0101;
    localparam logic [3:0] OPC_ADD  = 4'b0110;
    localparam logic [3:0] OPC_SUB  = 4'b0111;
    localparam logic [3:0] OPC_OR   = 4'b1000;
    localparam logic [3:0] OPC_SLT  = 4'b1001;
    localparam logic [3:0] OPC_SLL  = 4'b1010;
    localparam logic [3:0] OPC_SRL  = 4'b1011;

    localparam int Y_MSB = 15;
    localparam int Y_LSB = 13;
    localparam int X_MSB = 12;
    localparam int X_LSB = 10;
    localparam int I_MSB = 9;
    localparam int I_LSB = 6;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        FETCH_IMM,
        HOLD,
        HALT
    } fetch_state_e;

    function automatic logic [3:0] op_field(input logic [DATA_W-1:0] w);
        return w[I_MSB:I_LSB];
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-core instruction handshake plus the core's PC redirect path.
interface fetch_core_if;
    import isa_pkg::*;

    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] imm;
    logic              has_imm;
    logic [ADDR_W-1:0] instr_pc;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_target;
    logic              halted;

    modport master (
        output instr_valid, instr, imm, has_imm, instr_pc, halted,
        input  instr_ready, pc_load, pc_target
    );

    modport slave (
        input  instr_valid, instr, imm, has_imm, instr_pc, halted,
        output instr_ready, pc_load, pc_target
    );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter: load has priority over increment, increment wraps modulo 2^ADDR_W.
module fetch_pc_reg
    import isa_pkg::*;
(
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_val;
        end else if (inc) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: walks the PC through the translation lookup, pairs MVI
// with its immediate word and presents whole instructions to the core.
module fetch_unit
    import isa_pkg::*;
#(
    parameter int         PROG_LEN = 38,
    parameter logic [3:0] OP_MVI   = OPC_MVI
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              start,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] word,
    fetch_core_if.master      core
);

    localparam logic [ADDR_W:0] PROG_END = (ADDR_W+1)'(PROG_LEN);

    fetch_state_e      state_q, state_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic              has_imm_q, has_imm_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;

    logic [ADDR_W-1:0] pc;
    logic              pc_ld;
    logic              pc_inc;
    logic              pc_end;
    logic              target_end;

    fetch_pc_reg u_pc (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .load     (pc_ld),
        .load_val (core.pc_target),
        .inc      (pc_inc),
        .pc       (pc)
    );

    assign pc_end     = {1'b0, pc} >= PROG_END;
    assign target_end = {1'b0, core.pc_target} >= PROG_END;

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        imm_d      = imm_q;
        has_imm_d  = has_imm_q;
        instr_pc_d = instr_pc_q;
        halted_d   = halted_q;
        pc_ld      = 1'b0;
        pc_inc     = 1'b0;

        case (state_q)
            IDLE: begin
                if (core.pc_load) begin
                    pc_ld = 1'b1;
                end else if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                instr_d    = word;
                instr_pc_d = pc;
                pc_inc     = 1'b1;
                if (op_field(word) == OP_MVI) begin
                    has_imm_d = 1'b1;
                    state_d   = FETCH_IMM;
                end else begin
                    has_imm_d = 1'b0;
                    imm_d     = '0;
                    state_d   = HOLD;
                end
            end
            FETCH_IMM: begin
                imm_d   = word;
                pc_inc  = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (core.instr_ready) begin
                    if (pc_end) begin
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            HALT: begin
            end
            default: state_d = IDLE;
        endcase

        // A redirect overrides whatever the sequencer was doing, including an acceptance in HOLD.
        if (core.pc_load && (state_q != IDLE)) begin
            pc_ld  = 1'b1;
            pc_inc = 1'b0;
            if (target_end) begin
                halted_d = 1'b1;
                state_d  = HALT;
            end else begin
                halted_d = 1'b0;
                state_d  = FETCH;
            end
        end

        valid_d = (state_d == HOLD);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            imm_q      <= '0;
            has_imm_q  <= 1'b0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            imm_q      <= imm_d;
            has_imm_q  <= has_imm_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
        end
    end

    assign addr             = pc;
    assign core.instr_valid = valid_q;
    assign core.instr       = instr_q;
    assign core.imm         = imm_q;
    assign core.has_imm     = has_imm_q;
    assign core.instr_pc    = instr_pc_q;
    assign core.halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: ROM-backed lookup, scoreboard of expected instructions,
// redirect vector table and hand sequences for backpressure, halt and reset.
module tb_fetch_unit;

    logic        Clock;
    logic        Resetn;
    logic        start;
    logic [5:0]  addr;
    logic [15:0] word;
    logic [15:0] mem [64];

    fetch_core_if core_if();

    fetch_unit dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .start  (start),
        .addr   (addr),
        .word   (word),
        .core   (core_if.master)
    );

    assign word = mem[addr];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] imm;
        logic        has_imm;
        logic [5:0]  pc;
    } exp_t;

    typedef struct {
        logic [5:0]  target;
        bit          is_halt;
        logic [15:0] instr;
        logic [15:0] imm;
        logic        has_imm;
        int          lat;
        bit          halt_after;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[7];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   pop_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic push_model(input logic [5:0] p);
        exp_t e;
        e.instr = mem[p];
        e.pc    = p;
        if (mem[p][9:6] == 4'b0001) begin
            e.has_imm = 1'b1;
            e.imm     = mem[p + 6'd1];
        end else begin
            e.has_imm = 1'b0;
            e.imm     = 16'h0000;
        end
        sb_q.push_back(e);
    endtask

    task automatic push_const(input logic [15:0] i, input logic [15:0] m, input logic h,
                              input logic [5:0] p);
        exp_t e;
        e.instr = i; e.imm = m; e.has_imm = h; e.pc = p;
        sb_q.push_back(e);
    endtask

    // Caller raises start or pc_load right after an edge; counts edges until valid.
    task automatic wait_valid(input int exp_lat, input string nm);
        int cyc = 0;
        do begin
            @(posedge Clock); #1;
            cyc++;
            start = 1'b0;
            core_if.pc_load = 1'b0;
        end while (!core_if.instr_valid && cyc < 10);
        check(nm, 32'(cyc), 32'(exp_lat));
    endtask

    task automatic accept_until(input int target);
        int cyc = 0;
        core_if.instr_ready = 1'b1;
        do begin
            @(posedge Clock); #1;
            cyc++;
        end while (pop_cnt < target && cyc < 20);
        core_if.instr_ready = 1'b0;
        check("accept_count", 32'(pop_cnt), 32'(target));
    endtask

    always @(negedge Clock) begin
        if (Resetn && core_if.instr_valid && core_if.instr_ready) begin
            if (sb_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_instr: got instr 0x%0h at pc %0d, expected none",
                         core_if.instr, core_if.instr_pc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                pop_cnt++;
                check("sb_instr",    32'(core_if.instr),    32'(e.instr));
                check("sb_imm",      32'(core_if.imm),      32'(e.imm));
                check("sb_has_imm",  32'(core_if.has_imm),  32'(e.has_imm));
                check("sb_instr_pc", 32'(core_if.instr_pc), 32'(e.pc));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        mem[0] = 16'h0040; mem[1] = 16'h0002;
        mem[2] = 16'h0440; mem[3] = 16'h0003;
        mem[4] = 16'h0580;
        mem[5] = 16'h0840; mem[6] = 16'h0006;
        for (int i = 7; i < 37; i++) mem[i] = 16'h0600 + 16'(i);
        mem[37] = 16'h2180;

        vecs[0] = '{6'd0,  1'b0, 16'h0040, 16'h0002, 1'b1, 3, 1'b0};
        vecs[1] = '{6'd2,  1'b0, 16'h0440, 16'h0003, 1'b1, 3, 1'b0};
        vecs[2] = '{6'd4,  1'b0, 16'h0580, 16'h0000, 1'b0, 2, 1'b0};
        vecs[3] = '{6'd5,  1'b0, 16'h0840, 16'h0006, 1'b1, 3, 1'b0};
        vecs[4] = '{6'd40, 1'b1, 16'h0000, 16'h0000, 1'b0, 0, 1'b1};
        vecs[5] = '{6'd37, 1'b0, 16'h2180, 16'h0000, 1'b0, 2, 1'b1};
        vecs[6] = '{6'd0,  1'b0, 16'h0040, 16'h0002, 1'b1, 3, 1'b0};

        Resetn = 1'b0;
        start = 1'b0;
        core_if.instr_ready = 1'b0;
        core_if.pc_load = 1'b0;
        core_if.pc_target = 6'd0;

        #23;
        check("rst_valid",    32'(core_if.instr_valid), 32'd0);
        check("rst_halted",   32'(core_if.halted),      32'd0);
        check("rst_has_imm",  32'(core_if.has_imm),     32'd0);
        check("rst_instr",    32'(core_if.instr),       32'd0);
        check("rst_imm",      32'(core_if.imm),         32'd0);
        check("rst_instr_pc", 32'(core_if.instr_pc),    32'd0);
        check("rst_addr",     32'(addr),                32'd0);

        @(posedge Clock); #1;
        Resetn = 1'b1;
        @(posedge Clock); #1;

        // Free-running start, then backpressure at pc 4.
        core_if.instr_ready = 1'b1;
        push_model(6'd0);
        push_model(6'd2);
        push_model(6'd4);
        start = 1'b1;
        wait_valid(3, "start_latency");
        accept_until(2);
        cyc = 0;
        while (!core_if.instr_valid && cyc < 5) begin
            @(posedge Clock); #1;
            cyc++;
        end
        check("bp_valid_reached", 32'(core_if.instr_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            check("bp_valid",    32'(core_if.instr_valid), 32'd1);
            check("bp_instr",    32'(core_if.instr),       32'h0580);
            check("bp_instr_pc", 32'(core_if.instr_pc),    32'd4);
            check("bp_addr",     32'(addr),                32'd5);
        end
        @(posedge Clock); #1;
        push_model(6'd5);
        accept_until(4);

        // Redirect while the immediate of pc 0 is being fetched.
        core_if.pc_load = 1'b1;
        core_if.pc_target = 6'd0;
        @(posedge Clock); #1;
        core_if.pc_load = 1'b0;
        @(posedge Clock); #1;
        check("fimm_addr",  32'(addr),                32'd1);
        check("fimm_valid", 32'(core_if.instr_valid), 32'd0);
        core_if.pc_load = 1'b1;
        core_if.pc_target = 6'd5;
        push_const(16'h0840, 16'h0006, 1'b1, 6'd5);
        wait_valid(3, "redirect_latency");
        accept_until(5);

        for (int v = 0; v < 7; v++) begin
            repeat (3) @(posedge Clock);
            #1;
            core_if.pc_load = 1'b1;
            core_if.pc_target = vecs[v].target;
            if (vecs[v].is_halt) begin
                @(posedge Clock); #1;
                core_if.pc_load = 1'b0;
                check("vec_halt_now",    32'(core_if.halted),      32'd1);
                check("vec_halt_valid",  32'(core_if.instr_valid), 32'd0);
                repeat (3) @(posedge Clock);
                #1;
                check("vec_halt_stay",   32'(core_if.instr_valid), 32'd0);
                check("vec_halt_addr",   32'(addr),                32'(vecs[v].target));
            end else begin
                push_const(vecs[v].instr, vecs[v].imm, vecs[v].has_imm, vecs[v].target);
                wait_valid(vecs[v].lat, "vec_latency");
                check("vec_halted_low", 32'(core_if.halted), 32'd0);
                accept_until(pop_cnt + 1);
                repeat (2) @(posedge Clock);
                #1;
                check("vec_halted_after", 32'(core_if.halted), 32'(vecs[v].halt_after));
                if (vecs[v].halt_after)
                    check("vec_valid_after", 32'(core_if.instr_valid), 32'd0);
            end
        end

        // Asynchronous reset landing in FETCH_IMM.
        core_if.pc_load = 1'b1;
        core_if.pc_target = 6'd0;
        @(posedge Clock); #1;
        core_if.pc_load = 1'b0;
        @(posedge Clock); #1;
        check("pre_rst_addr", 32'(addr), 32'd1);
        Resetn = 1'b0;
        #1;
        check("mid_rst_valid",    32'(core_if.instr_valid), 32'd0);
        check("mid_rst_halted",   32'(core_if.halted),      32'd0);
        check("mid_rst_has_imm",  32'(core_if.has_imm),     32'd0);
        check("mid_rst_instr",    32'(core_if.instr),       32'd0);
        check("mid_rst_imm",      32'(core_if.imm),         32'd0);
        check("mid_rst_instr_pc", 32'(core_if.instr_pc),    32'd0);
        check("mid_rst_addr",     32'(addr),                32'd0);
        repeat (2) @(posedge Clock);
        #1;
        Resetn = 1'b1;
        @(posedge Clock); #1;
        push_model(6'd0);
        start = 1'b1;
        wait_valid(3, "restart_latency");
        accept_until(pop_cnt + 1);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
